display_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment display controller for N common-anode digits.

---
 rtl/display_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner: strobed shadow capture, tear-free
// frame-boundary display update, leading-zero blanking, per-digit dp and PWM dimming.
module display_scan_ctrl #(
    parameter int N_DIGITS = 8,
    parameter int PRESC_W  = 17,
    parameter int BRIGHT_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   din,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    w_display,
    input  logic                    lz_en,
    input  logic [BRIGHT_W-1:0]     bright,
    input  logic                    disp_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    localparam int                IDX_W    = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ONE_HOT0 = {{(N_DIGITS-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0]    cnt;
    logic [IDX_W-1:0]      idx;
    logic                  tick;
    logic                  wrap;

    logic [4*N_DIGITS-1:0] shadow_data;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic                  pending;
    logic [4*N_DIGITS-1:0] disp_data;
    logic [N_DIGITS-1:0]   disp_dp;

    logic [3:0]            cur_nib;
    logic [N_DIGITS-1:0]   blank_vec;
    logic                  zero_run;
    logic                  lit;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [N_DIGITS-1:0]   an_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        // Active-low {g,f,e,d,c,b,a}
        case (h)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    assign tick = &cnt;
    assign wrap = tick && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + PRESC_W'(1);
            if (tick) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Shadow captures on every strobe; the visible copy only moves at a frame wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            pending     <= 1'b0;
            disp_data   <= '0;
            disp_dp     <= '0;
        end else begin
            // NOTE: non-blocking assignments make the wrap copy read the shadow value
            // from before this edge, so a strobe on the wrap edge waits for the next frame.
            if (wrap && pending) begin
                disp_data <= shadow_data;
                disp_dp   <= shadow_dp;
            end
            if (w_display) begin
                shadow_data <= din;
                shadow_dp   <= dp_in;
            end
            if (w_display) begin
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a latch behind.
        zero_run  = lz_en;
        blank_vec = '0;
        // NOTE: blocking assignments here let zero_run accumulate down the digit chain.
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run     = zero_run && (disp_data[4*k +: 4] == 4'h0);
            blank_vec[k] = zero_run;
        end
    end

    always_comb begin
        cur_nib  = disp_data[4*idx +: 4];
        lit      = disp_en && (cnt[PRESC_W-1 -: BRIGHT_W] <= bright);
        seg_next = (!disp_en || blank_vec[idx]) ? 7'h7F : hex_to_seg(cur_nib);
        dp_next  = disp_en ? ~disp_dp[idx] : 1'b1;
        an_next  = lit ? ~(ONE_HOT0 << idx) : '1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg        <= 7'h7F;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            dp         <= dp_next;
            an         <= an_next;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: cycle-accurate reference model, a table of
// display patterns with hand-decoded segments, and hand-written multi-cycle corner cases.
module tb_display_scan_ctrl;

    localparam int N     = 4;
    localparam int PW    = 4;
    localparam int BW    = 2;
    localparam int SLOT  = 1 << PW;
    localparam int FRAME = N * SLOT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   din = '0;
    logic [3:0]    dp_in = '0;
    logic          w_display = 1'b0;
    logic          lz_en = 1'b0;
    logic [1:0]    bright = 2'd3;
    logic          disp_en = 1'b1;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_done;

    display_scan_ctrl #(.N_DIGITS(N), .PRESC_W(PW), .BRIGHT_W(BW)) dut (
        .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .w_display(w_display),
        .lz_en(lz_en), .bright(bright), .disp_en(disp_en),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input bit ok, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    // Reference model: everything is derived from the count of clock edges since reset.
    logic [6:0]  lut [16];
    int unsigned k;
    logic [15:0] m_sh, m_disp;
    logic [3:0]  m_sdp, m_ddp;
    bit          m_pend;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_fd;

    task automatic model_reset();
        k = 0; m_sh = '0; m_disp = '0; m_sdp = '0; m_ddp = '0; m_pend = 0;
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
    endtask

    task automatic model_edge();
        int  c, i;
        bit  blank, lit, wrap;
        if (!rst) begin
            model_reset();
            return;
        end
        c     = int'(k % SLOT);
        i     = int'((k / SLOT) % N);
        blank = lz_en && (i != 0) && ((m_disp >> (4*i)) == 16'h0);
        lit   = disp_en && ((c >> (PW - BW)) <= int'(bright));
        e_seg = (!disp_en || blank) ? 7'h7F : lut[m_disp[4*i +: 4]];
        e_dp  = disp_en ? ~m_ddp[i] : 1'b1;
        e_an  = lit ? ~(4'b0001 << i) : 4'hF;
        wrap  = (k % FRAME) == FRAME - 1;
        e_fd  = wrap;
        if (wrap && m_pend) begin
            m_disp = m_sh; m_ddp = m_sdp; m_pend = 0;
        end
        if (w_display) begin
            m_sh = din; m_sdp = dp_in; m_pend = 1;
        end
        k++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("cycle", seg === e_seg && dp === e_dp && an === e_an && frame_done === e_fd,
              $sformatf("edge=%0d seg got %h exp %h, dp got %b exp %b, an got %h exp %h, fd got %b exp %b",
                        k, seg, e_seg, dp, e_dp, an, e_an, frame_done, e_fd));
    endtask

    task automatic write(input logic [15:0] d, input logic [3:0] p);
        din = d; dp_in = p; w_display = 1'b1;
        step();
        w_display = 1'b0;
    endtask

    task automatic wait_fd(output int steps);
        steps = 0;
        for (int t = 0; t < 3*FRAME; t++) begin
            step();
            steps++;
            if (frame_done === 1'b1) return;
        end
        check("fd_timeout", 1'b0, $sformatf("no frame_done within %0d clks", 3*FRAME));
    endtask

    logic [6:0] seg_seen [N];
    logic       dp_seen  [N];
    int         lit_cnt  [N];
    int         dark_cnt;
    bit         fd_seen;

    task automatic scan_frame();
        for (int d = 0; d < N; d++) begin
            seg_seen[d] = 'x; dp_seen[d] = 'x; lit_cnt[d] = 0;
        end
        dark_cnt = 0; fd_seen = 0;
        for (int t = 0; t < FRAME; t++) begin
            step();
            if (frame_done === 1'b1) fd_seen = 1;
            if (an == 4'hF) dark_cnt++;
            for (int d = 0; d < N; d++) begin
                if (an == ~(4'b0001 << d)) begin
                    seg_seen[d] = seg; dp_seen[d] = dp; lit_cnt[d]++;
                end
            end
        end
    endtask

    typedef struct {
        logic [15:0]     din;
        logic [3:0]      dp_in;
        logic            lz;
        logic [3:0][6:0] seg_exp;   // {digit3, digit2, digit1, digit0}
        logic [3:0]      dp_exp;    // active-low dp seen on each digit
    } vec_t;

    vec_t vecs [8];
    int   n;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111};
        vecs[1] = '{16'h3456, 4'b0101, 1'b0, {7'h30, 7'h19, 7'h12, 7'h02}, 4'b1010};
        vecs[2] = '{16'h789B, 4'b0000, 1'b0, {7'h78, 7'h00, 7'h10, 7'h03}, 4'b1111};
        vecs[3] = '{16'hCDE0, 4'b0000, 1'b0, {7'h46, 7'h21, 7'h06, 7'h40}, 4'b1111};
        vecs[4] = '{16'h0070, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1111};
        vecs[5] = '{16'h0070, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h78, 7'h40}, 4'b1111};
        vecs[6] = '{16'h0000, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111};
        vecs[7] = '{16'h0F00, 4'b0000, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h40}, 4'b1111};

        model_reset();
        #2 rst = 1'b0;
        #1;
        check("reset", seg === 7'h7F && dp === 1'b1 && an === 4'hF && frame_done === 1'b0,
              $sformatf("seg=%h dp=%b an=%h fd=%b", seg, dp, an, frame_done));
        repeat (3) step();
        rst = 1'b1;

        // Idle scan: all '0', full brightness, frame every 64 clks.
        wait_fd(n);
        check("first_frame", n == FRAME, $sformatf("got %0d clks, want %0d", n, FRAME));
        scan_frame();
        check("idle_fd", fd_seen, "frame_done missing in idle frame");
        for (int d = 0; d < N; d++) begin
            check("idle_lit", lit_cnt[d] == SLOT, $sformatf("digit %0d lit %0d, want %0d", d, lit_cnt[d], SLOT));
            check("idle_seg", seg_seen[d] === 7'h40, $sformatf("digit %0d seg %h, want 40", d, seg_seen[d]));
        end

        // Table: patterns, decimal points and leading-zero blanking.
        foreach (vecs[v]) begin
            lz_en = vecs[v].lz;
            write(vecs[v].din, vecs[v].dp_in);
            wait_fd(n);
            scan_frame();
            for (int d = 0; d < N; d++) begin
                check($sformatf("vec%0d_seg%0d", v, d), seg_seen[d] === vecs[v].seg_exp[d],
                      $sformatf("got %h want %h", seg_seen[d], vecs[v].seg_exp[d]));
                check($sformatf("vec%0d_dp%0d", v, d), dp_seen[d] === vecs[v].dp_exp[d],
                      $sformatf("got %b want %b", dp_seen[d], vecs[v].dp_exp[d]));
            end
        end
        lz_en = 1'b0;

        // Strobe on the wrap edge: the earlier pending write shows first, the new one a frame later.
        write(16'h1111, 4'b0000);
        repeat (FRAME - 2) step();
        din = 16'h5555; w_display = 1'b1;
        step();
        w_display = 1'b0;
        check("coinc_fd", frame_done === 1'b1, $sformatf("fd got %b want 1", frame_done));
        scan_frame();
        check("coinc_old", seg_seen[0] === 7'h79, $sformatf("digit0 got %h want 79", seg_seen[0]));
        check("coinc_old3", seg_seen[3] === 7'h79, $sformatf("digit3 got %h want 79", seg_seen[3]));
        scan_frame();
        check("coinc_new", seg_seen[0] === 7'h12, $sformatf("digit0 got %h want 12", seg_seen[0]));
        scan_frame();
        check("coinc_hold", seg_seen[2] === 7'h12, $sformatf("digit2 got %h want 12", seg_seen[2]));

        // Brightness duty and display disable.
        bright = 2'd0;
        scan_frame();
        for (int d = 0; d < N; d++)
            check("bright0", lit_cnt[d] == 4, $sformatf("digit %0d lit %0d want 4", d, lit_cnt[d]));
        bright = 2'd1;
        scan_frame();
        for (int d = 0; d < N; d++)
            check("bright1", lit_cnt[d] == 8, $sformatf("digit %0d lit %0d want 8", d, lit_cnt[d]));
        bright = 2'd3;
        disp_en = 1'b0;
        scan_frame();
        check("disp_off_an", dark_cnt == FRAME, $sformatf("dark %0d want %0d", dark_cnt, FRAME));
        check("disp_off_fd", fd_seen, "frame_done missing while disabled");
        disp_en = 1'b1;

        // Reset mid-slot discards a pending write.
        write(16'h8888, 4'b0100);
        repeat (5) step();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async_reset", seg === 7'h7F && dp === 1'b1 && an === 4'hF && frame_done === 1'b0,
              $sformatf("seg=%h dp=%b an=%h fd=%b", seg, dp, an, frame_done));
        repeat (3) step();
        rst = 1'b1;
        wait_fd(n);
        check("rst_frame", n == FRAME, $sformatf("got %0d clks, want %0d", n, FRAME));
        scan_frame();
        for (int d = 0; d < N; d++) begin
            check("rst_seg", seg_seen[d] === 7'h40, $sformatf("digit %0d seg %h want 40", d, seg_seen[d]));
            check("rst_dp", dp_seen[d] === 1'b1, $sformatf("digit %0d dp %b want 1", d, dp_seen[d]));
        end

        // Randomised traffic against the model.
        repeat (1500) begin
            w_display = ($urandom_range(0, 15) == 0);
            din       = 16'($urandom);
            dp_in     = 4'($urandom);
            if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
            if ($urandom_range(0, 31) == 0) bright = 2'($urandom);
            disp_en   = ($urandom_range(0, 31) != 0);
            step();
        end
        w_display = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
